// File: rtl/pipeline_hazard_ctrl_if.sv
// Interface between the pipeline datapath and the hazard controller.
// The controller uses the slave modport and the datapath uses the master modport.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        use_rs2_id;
  logic [4:0]  rd_ex;
  logic        memread_ex;
  logic        branch_taken_ex;
  logic        mc_start_ex;
  logic        mc_done;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        id_ex_en;
  logic        id_ex_bubble;
  logic        ex_mem_bubble;
  logic        busy;
  logic        mc_timeout;
  logic [31:0] stall_cycles;

  modport master (
    output rs1_id, rs2_id, use_rs2_id, rd_ex, memread_ex,
           branch_taken_ex, mc_start_ex, mc_done,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_bubble, busy, mc_timeout, stall_cycles
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs2_id, rd_ex, memread_ex,
           branch_taken_ex, mc_start_ex, mc_done,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
           ex_mem_bubble, busy, mc_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, multi-cycle EX waits.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles performance counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 10
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MCWAIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] MC_LIMIT = CNT_W'(MC_TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en;
  logic             id_ex_bubble, ex_mem_bubble, mc_timeout;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign hz = bus.memread_ex && (bus.rd_ex != 5'd0) &&
              ((bus.rd_ex == bus.rs1_id) ||
               (bus.use_rs2_id && (bus.rd_ex == bus.rs2_id)));

  // NOTE: every output and next-state variable gets a default before any branch,
  // otherwise paths that skip an assignment would infer latches.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mc_timeout    = 1'b0;

    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (bus.branch_taken_ex) begin
            // The ID instruction is squashed, so any coincident load-use hazard is moot.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (bus.mc_start_ex && !bus.mc_done) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            state_d       = MCWAIT;
            cnt_d         = CNT_W'(1);
          end else if (hz) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LDSTALL;
              cnt_d   = LD_INIT;
            end
          end
        end

        LDSTALL: begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        MCWAIT: begin
          if (bus.mc_done) begin
            state_d = RUN;
            cnt_d   = '0;
          end else if (cnt_q >= MC_LIMIT) begin
            mc_timeout = 1'b1;
            state_d    = RUN;
            cnt_d      = '0;
          end else begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            cnt_d         = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.id_ex_bubble  = id_ex_bubble;
  assign bus.ex_mem_bubble = ex_mem_bubble;
  assign bus.mc_timeout    = mc_timeout;
  assign bus.busy          = !rst && (state_q != RUN);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (!pc_en && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
`else
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: two instances (LOAD_LAT=1 and 3, MC_TIMEOUT=8)
// share one stimulus stream and are checked against hand-computed output vectors.
module tb_pipeline_hazard_ctrl;

  // Output vector order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, busy, mc_timeout}
  localparam logic [7:0] NORM    = 8'b1101_0000;
  localparam logic [7:0] HZ      = 8'b0001_1000;
  localparam logic [7:0] LDS     = 8'b0001_1010;
  localparam logic [7:0] BR      = 8'b1111_1000;
  localparam logic [7:0] MCS     = 8'b0000_0100;
  localparam logic [7:0] MCW     = 8'b0000_0110;
  localparam logic [7:0] MC_DONE = 8'b1101_0010;
  localparam logic [7:0] MC_TO   = 8'b1101_0011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        use2, memrd, br, mcs, mcd;
  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_sc_a = '0;
  logic [31:0] exp_sc_b = '0;
  logic [7:0]  out_a, out_b;

  pipeline_hazard_ctrl_if if_a ();
  pipeline_hazard_ctrl_if if_b ();

  assign if_a.rs1_id = rs1;  assign if_b.rs1_id = rs1;
  assign if_a.rs2_id = rs2;  assign if_b.rs2_id = rs2;
  assign if_a.use_rs2_id = use2;  assign if_b.use_rs2_id = use2;
  assign if_a.rd_ex = rd;  assign if_b.rd_ex = rd;
  assign if_a.memread_ex = memrd;  assign if_b.memread_ex = memrd;
  assign if_a.branch_taken_ex = br;  assign if_b.branch_taken_ex = br;
  assign if_a.mc_start_ex = mcs;  assign if_b.mc_start_ex = mcs;
  assign if_a.mc_done = mcd;  assign if_b.mc_done = mcd;

  assign out_a = {if_a.pc_en, if_a.if_id_en, if_a.if_id_flush, if_a.id_ex_en,
                  if_a.id_ex_bubble, if_a.ex_mem_bubble, if_a.busy, if_a.mc_timeout};
  assign out_b = {if_b.pc_en, if_b.if_id_en, if_b.if_id_flush, if_b.id_ex_en,
                  if_b.id_ex_bubble, if_b.ex_mem_bubble, if_b.busy, if_b.mc_timeout};

  pipeline_hazard_ctrl #(.LOAD_LAT(1), .MC_TIMEOUT(8), .CNT_W(10)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  pipeline_hazard_ctrl #(.LOAD_LAT(3), .MC_TIMEOUT(8), .CNT_W(10)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rdx, input logic mr, input logic b,
                       input logic ms, input logic md);
    rs1 = r1; rs2 = r2; use2 = u2; rd = rdx; memrd = mr; br = b; mcs = ms; mcd = md;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    checks++;
    assert (out_a === ea) passes++;
    else $error("FAIL %s dut_a outputs observed=%b expected=%b", tag, out_a, ea);
    checks++;
    assert (out_b === eb) passes++;
    else $error("FAIL %s dut_b outputs observed=%b expected=%b", tag, out_b, eb);
    checks++;
    assert (if_a.stall_cycles === exp_sc_a) passes++;
    else $error("FAIL %s dut_a stall_cycles observed=%0d expected=%0d", tag, if_a.stall_cycles, exp_sc_a);
    checks++;
    assert (if_b.stall_cycles === exp_sc_b) passes++;
    else $error("FAIL %s dut_b stall_cycles observed=%0d expected=%0d", tag, if_b.stall_cycles, exp_sc_b);
`ifdef HAZARD_PERF_CNT_EN
    if (!ea[7]) exp_sc_a++;
    if (!eb[7]) exp_sc_b++;
`endif
    if (rst) begin
      exp_sc_a = '0;
      exp_sc_b = '0;
    end
  endtask

  // Sample Mealy outputs at the falling edge, then advance past the next rising edge.
  task automatic step(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    @(negedge clk);
    check(tag, ea, eb);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk); @(posedge clk); #1;

    // Reset forces default outputs even with hazard and mc_start present.
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    step("reset_defaults", NORM, NORM);
    rst = 1'b0;
    idle();
    step("idle_run", NORM, NORM);

    // Load-use on rs1: one stall for LOAD_LAT=1, three for LOAD_LAT=3.
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ld_use_rs1_c1", HZ, HZ);
    idle();
    step("ld_use_rs1_c2", NORM, LDS);
    step("ld_use_rs1_c3", NORM, LDS);
    step("ld_use_rs1_after", NORM, NORM);

    // x0 never hazards.
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("x0_no_hazard", NORM, NORM);

    // rs2 match only counts when rs2 is read.
    drive(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rs2_unused", NORM, NORM);
    drive(5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ld_use_rs2_c1", HZ, HZ);
    idle();
    step("ld_use_rs2_c2", NORM, LDS);
    step("ld_use_rs2_c3", NORM, LDS);
    step("ld_use_rs2_after", NORM, NORM);

    // Branch outranks a coincident load-use hazard.
    drive(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    step("branch_with_hz", BR, BR);
    idle();
    step("branch_after", NORM, NORM);

    // mc_done together with mc_start: no stall.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step("mc_start_done_same", NORM, NORM);

    // Multi-cycle op with done in the sixth cycle: five frozen cycles.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mc_done5_start", MCS, MCS);
    for (int i = 1; i <= 4; i++) step("mc_done5_wait", MCW, MCW);
    mcd = 1'b1;
    step("mc_done5_release", MC_DONE, MC_DONE);
    idle();
    step("mc_done5_after", NORM, NORM);

    // Timeout: cnt counts 1..7 frozen, release with pulse at cnt==8.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mc_to_start", MCS, MCS);
    for (int i = 1; i <= 7; i++) step("mc_to_wait", MCW, MCW);
    step("mc_to_release", MC_TO, MC_TO);
    idle();
    step("mc_to_pulse_end", NORM, NORM);

    // Done arriving in the timeout cycle wins: no pulse.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mc_late_start", MCS, MCS);
    for (int i = 1; i <= 7; i++) step("mc_late_wait", MCW, MCW);
    mcd = 1'b1;
    step("mc_late_done", MC_DONE, MC_DONE);
    idle();
    step("mc_late_after", NORM, NORM);

    // Reset in cycle 4 of a multi-cycle wait aborts without a pulse.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mc_rst_start", MCS, MCS);
    for (int i = 1; i <= 3; i++) step("mc_rst_wait", MCW, MCW);
    rst = 1'b1;
    step("mc_rst_assert", NORM, NORM);
    rst = 1'b0;
    idle();
    step("mc_rst_after", NORM, NORM);

    // Fresh multi-cycle op after reset restarts the counter at 1.
    drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mc_post_rst_start", MCS, MCS);
    for (int i = 1; i <= 7; i++) step("mc_post_rst_wait", MCW, MCW);
    step("mc_post_rst_to", MC_TO, MC_TO);
    idle();
    step("mc_post_rst_after", NORM, NORM);

    // Reset during the long load stall aborts it.
    drive(5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ld_rst_c1", HZ, HZ);
    idle();
    rst = 1'b1;
    step("ld_rst_assert", NORM, NORM);
    rst = 1'b0;
    step("ld_rst_after", NORM, NORM);
    step("ld_rst_final", NORM, NORM);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage segmented core: decides each cycle whether PC, IF/ID and ID/EX advance, stall, flush or take a bubble.
- Handles three cases: load-use hazards that operand forwarding cannot cover, taken-branch flushes, and multi-cycle EX operations with a done handshake and a timeout.
- Sits beside the forwarding unit and drives the pipeline-register enables and clears.

Parameters:
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..15).
- MC_TIMEOUT, 64, maximum MCWAIT cycles before forced release (2..1023).
- CNT_W, 10, width of internal cycle counter; must hold MC_TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rs1_id  in  5  ID-stage source register 1.
- rs2_id  in  5  ID-stage source register 2.
- use_rs2_id  in  1  ID instruction reads rs2 (R-type, store, branch).
- rd_ex  in  5  EX-stage destination register.
- memread_ex  in  1  EX instruction is a load.
- branch_taken_ex  in  1  branch/jump resolved taken in EX.
- mc_start_ex  in  1  multi-cycle operation present in EX this cycle.
- mc_done  in  1  multi-cycle unit result valid.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_bubble  out  1  load NOP into ID/EX.
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- busy  out  1  state != RUN.
- mc_timeout  out  1  one-cycle pulse on forced MCWAIT release.
- stall_cycles  out  32  stall cycle count (optional feature).

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset: while rst=1, state=RUN, cnt=0, mc_timeout=0, stall_cycles=0. Outputs forced to pc_en=if_id_en=id_ex_en=1, all flush/bubble=0, busy=0. Reset mid-stall or mid-MCWAIT aborts immediately; no timeout pulse.
- Outputs are Mealy: decoded from the registered state plus current inputs. Default is all enables 1, flush/bubble 0.
- Load-use hazard: hz = memread_ex & rd_ex!=0 & (rd_ex==rs1_id | (use_rs2_id & rd_ex==rs2_id)). Register x0 never causes a hazard.
- RUN priority, highest first:
  1) branch_taken_ex: if_id_flush=1, id_ex_bubble=1, pc_en=1; stay RUN. A coincident hz is ignored because the ID instruction is squashed.
  2) mc_start_ex & !mc_done: pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1; go to MCWAIT, cnt=1. If mc_done is also 1, no stall.
  3) hz: pc_en=if_id_en=0, id_ex_bubble=1. If LOAD_LAT=1, stay RUN. Otherwise go to LDSTALL with cnt=LOAD_LAT-1.
- LDSTALL:
  - Outputs as for hz (pc/IF-ID held, ID/EX bubble); cnt decrements each cycle.
  - Transition to RUN in the cycle cnt==1, so total stall = LOAD_LAT cycles.
  - Inputs branch_taken_ex and mc_start_ex are ignored (EX holds bubbles).
- MCWAIT:
  - pc/if_id/id_ex enables 0, ex_mem_bubble=1.
  - mc_done=1: release this cycle (enables 1, ex_mem_bubble 0) and go to RUN.
  - Else if cnt==MC_TIMEOUT: release this cycle, mc_timeout=1, go to RUN.
  - Else cnt++.
  - mc_done arriving in the timeout cycle counts as done; no timeout pulse.
- busy = (state != RUN).
- Counter saturates and never wraps.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cycles is a 32-bit register, cleared by rst. It increments by 1 every cycle pc_en=0 and saturates at 0xFFFFFFFF.
- Undefined: stall_cycles tied to 0 and no counter flops are synthesized.

Test Plan:
- Load x5 in EX (memread_ex=1, rd_ex=5), ID rs1_id=5, LOAD_LAT=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1, then normal flow; busy stays 0.
- Same hazard with LOAD_LAT=3 -> exactly 3 stall cycles, busy=1 during cycles 2-3, RUN afterwards; rd_ex=0 with rs1_id=0 -> no stall.
- branch_taken_ex=1 together with a load-use hz -> if_id_flush=1, id_ex_bubble=1, pc_en=1 for one cycle; no stall.
- mc_start_ex=1, mc_done after 5 cycles -> 5 frozen cycles with ex_mem_bubble=1, release in the done cycle, mc_timeout=0; with mc_done=1 in the same cycle as mc_start_ex -> zero stall.
- MC_TIMEOUT=8, mc_done never asserted -> release at cnt=8 with a one-cycle mc_timeout=1 pulse; rst=1 at cycle 4 of a repeat -> state RUN and outputs at reset values next edge, no pulse.
- With HAZARD_PERF_CNT_EN defined, run the above scenarios -> stall_cycles equals the total number of pc_en=0 cycles; rst clears it to 0.
